// File: rtl/lfsr_gen_if.sv
// Handshake/status bundle between an LFSR sequence generator and its consumer.
// The master side drives the controls; lfsr_gen connects through the slave modport.
interface lfsr_gen_if #(
   parameter int WIDTH = 16
) ();
   logic             en;
   logic             load;
   logic [WIDTH-1:0] seed;
   logic             out_ready;
   logic             out_valid;
   logic [WIDTH-1:0] lfsr_out;
   logic [WIDTH-1:0] step_cnt;
   logic             period_done;
   logic             lockup;

   modport master (
      output en, load, seed, out_ready,
      input  out_valid, lfsr_out, step_cnt, period_done, lockup
   );

   modport slave (
      input  en, load, seed, out_ready,
      output out_valid, lfsr_out, step_cnt, period_done, lockup
   );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci LFSR word generator with valid/ready output, seed load and period detection.
// Optional macro LFSR_GEN_LOCKUP_EN replaces all-zero seeds/states with 1 and pulses lockup.
module lfsr_gen #(
   parameter int             WIDTH      = 16,
   parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
   parameter int             STEP       = 1,
   parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
   input logic      clk,
   input logic      resetn,
   lfsr_gen_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] lfsr_r;
   logic [WIDTH-1:0] start_r;
   logic [WIDTH-1:0] cnt_r;
   logic             valid_r;
   logic             period_r;

   logic [WIDTH-1:0] shifted_s;
   logic [WIDTH-1:0] step_val_s;
   logic [WIDTH-1:0] seed_val_s;
   logic             step_fix_s;
   logic             seed_fix_s;
   logic             accept_s;

   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
      return {s[WIDTH-2:0], ^(s & TAPS)};
   endfunction

   function automatic logic [WIDTH-1:0] shift_n(input logic [WIDTH-1:0] s);
      logic [WIDTH-1:0] v;
      v = s;
      for (int i = 0; i < STEP; i++) begin
         v = shift_once(v);
      end
      return v;
   endfunction

   // valid_r is only ever set in RUN, so it doubles as the RUN qualifier
   assign accept_s = valid_r & bus.out_ready;

   // Next word after STEP shifts, and the value a load would install
   always_comb begin
      shifted_s  = shift_n(lfsr_r);
      step_val_s = shifted_s;
      seed_val_s = bus.seed;
      step_fix_s = 1'b0;
      seed_fix_s = 1'b0;
`ifdef LFSR_GEN_LOCKUP_EN
      if (shifted_s == '0) begin
         step_val_s = WIDTH'(1);
         step_fix_s = 1'b1;
      end else begin
         step_val_s = shifted_s;
         step_fix_s = 1'b0;
      end
      if (bus.seed == '0) begin
         seed_val_s = WIDTH'(1);
         seed_fix_s = 1'b1;
      end else begin
         seed_val_s = bus.seed;
         seed_fix_s = 1'b0;
      end
`endif
   end

   // Control FSM with registered word, counter, valid and period pulse
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r  <= IDLE;
         lfsr_r   <= RESET_SEED;
         start_r  <= RESET_SEED;
         cnt_r    <= '0;
         valid_r  <= 1'b0;
         period_r <= 1'b0;
      end else begin
         period_r <= 1'b0;
         if (bus.load) begin
            // load wins over a step accepted in the same cycle
            lfsr_r  <= seed_val_s;
            start_r <= seed_val_s;
            cnt_r   <= '0;
            state_r <= bus.en ? RUN : HOLD;
            valid_r <= bus.en;
         end else begin
            case (state_r)
               IDLE: begin
                  if (bus.en) begin
                     state_r <= RUN;
                     valid_r <= 1'b1;
                     lfsr_r  <= RESET_SEED;
                     start_r <= RESET_SEED;
                  end else begin
                     valid_r <= 1'b0;
                  end
               end
               RUN: begin
                  if (accept_s) begin
                     lfsr_r   <= step_val_s;
                     cnt_r    <= cnt_r + WIDTH'(1);
                     period_r <= (step_val_s == start_r);
                  end else begin
                     lfsr_r <= lfsr_r;
                  end
                  if (!bus.en) begin
                     state_r <= HOLD;
                     valid_r <= 1'b0;
                  end else begin
                     valid_r <= 1'b1;
                  end
               end
               HOLD: begin
                  if (bus.en) begin
                     state_r <= RUN;
                     valid_r <= 1'b1;
                  end else begin
                     valid_r <= 1'b0;
                  end
               end
               default: begin
                  state_r <= IDLE;
                  valid_r <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef LFSR_GEN_LOCKUP_EN
   logic lockup_r;

   // One-cycle pulse whenever an all-zero value was replaced by 1
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lockup_r <= 1'b0;
      end else if (bus.load) begin
         lockup_r <= seed_fix_s;
      end else if (accept_s) begin
         lockup_r <= step_fix_s;
      end else begin
         lockup_r <= 1'b0;
      end
   end

   assign bus.lockup = lockup_r;
`else
   assign bus.lockup = 1'b0;
`endif

   assign bus.out_valid   = valid_r;
   assign bus.lfsr_out    = lfsr_r;
   assign bus.step_cnt    = cnt_r;
   assign bus.period_done = period_r;

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a STEP=1 and a STEP=4 instance share one stimulus stream
// and are compared every cycle against a behavioural reference model.
module tb_lfsr_gen;

   localparam logic [15:0] TAPS = 16'hB400;
   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_RUN  = 2'd1;
   localparam logic [1:0]  S_HOLD = 2'd2;
`ifdef LFSR_GEN_LOCKUP_EN
   localparam logic [15:0] ZERO_EXP  = 16'h0001;
   localparam logic        ZERO_LOCK = 1'b1;
`else
   localparam logic [15:0] ZERO_EXP  = 16'h0000;
   localparam logic        ZERO_LOCK = 1'b0;
`endif

   typedef struct packed {
      logic [1:0]  st;
      logic [15:0] lfsr;
      logic [15:0] start;
      logic [15:0] cnt;
      logic        valid;
      logic        period;
      logic        lock;
   } mdl_t;

   typedef struct {
      bit    chk;
      string phase;
      mdl_t  a;
      mdl_t  b;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic        load;
   logic [15:0] seed;
   logic        out_ready;

   int    n_checks = 0;
   int    n_errors = 0;
   int    per_pulses = 0;
   string phase = "init";
   mdl_t  m1;
   mdl_t  m4;
   exp_t  q[$];

   lfsr_gen_if #(.WIDTH(16)) if1 ();
   lfsr_gen_if #(.WIDTH(16)) if4 ();

   assign if1.en = en;  assign if1.load = load;  assign if1.seed = seed;  assign if1.out_ready = out_ready;
   assign if4.en = en;  assign if4.load = load;  assign if4.seed = seed;  assign if4.out_ready = out_ready;

   lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .STEP(1), .RESET_SEED(16'h0001)) u_d1 (
      .clk(clk), .resetn(resetn), .bus(if1)
   );
   lfsr_gen #(.WIDTH(16), .TAPS(16'hB400), .STEP(4), .RESET_SEED(16'h0001)) u_d4 (
      .clk(clk), .resetn(resetn), .bus(if4)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] ref_shift(input logic [15:0] s);
      logic fb;
      fb = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (TAPS[i]) fb = fb ^ s[i];
      end
      return {s[14:0], fb};
   endfunction

   function automatic mdl_t mdl_rst();
      mdl_t m;
      m = '0;
      m.st = S_IDLE;  m.lfsr = 16'h0001;  m.start = 16'h0001;
      return m;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t m, input int nshift, input logic e,
                                     input logic l, input logic [15:0] s, input logic r);
      mdl_t        n;
      logic [15:0] v;
      n = m;
      n.period = 1'b0;
      n.lock = 1'b0;
      if (l) begin
         v = s;
`ifdef LFSR_GEN_LOCKUP_EN
         if (v == 16'h0000) begin v = 16'h0001; n.lock = 1'b1; end
`endif
         n.lfsr = v;  n.start = v;  n.cnt = 16'h0000;
         n.st = e ? S_RUN : S_HOLD;
      end else if (m.st == S_IDLE) begin
         if (e) begin n.st = S_RUN; n.start = 16'h0001; n.lfsr = 16'h0001; end
      end else if (m.st == S_RUN) begin
         if (r) begin
            v = m.lfsr;
            for (int k = 0; k < nshift; k++) v = ref_shift(v);
`ifdef LFSR_GEN_LOCKUP_EN
            if (v == 16'h0000) begin v = 16'h0001; n.lock = 1'b1; end
`endif
            n.lfsr = v;
            n.cnt = m.cnt + 16'd1;
            n.period = (v == m.start);
         end
         if (!e) n.st = S_HOLD;
      end else begin
         if (e) n.st = S_RUN;
      end
      n.valid = (n.st == S_RUN);
      return n;
   endfunction

   task automatic drive(input logic e, input logic l, input logic [15:0] s, input logic r, input bit c);
      exp_t x;
      @(negedge clk);
      en = e;  load = l;  seed = s;  out_ready = r;
      m1 = mdl_step(m1, 1, e, l, s, r);
      m4 = mdl_step(m4, 4, e, l, s, r);
      x.chk = c || m1.period || m4.period;
      x.phase = phase;
      x.a = m1;
      x.b = m4;
      q.push_back(x);
   endtask

   task automatic expect_now(input string tag, input logic [15:0] lf, input logic [15:0] cn);
      @(posedge clk);
      #2;
      check_value({tag, ".lfsr"}, 32'(if1.lfsr_out), 32'(lf));
      check_value({tag, ".cnt"}, 32'(if1.step_cnt), 32'(cn));
   endtask

   task automatic reset_check(input string tag);
      check_value({tag, ".lfsr"}, 32'(if1.lfsr_out), 32'h1);
      check_value({tag, ".cnt"}, 32'(if1.step_cnt), 32'h0);
      check_value({tag, ".valid"}, 32'(if1.out_valid), 32'h0);
      check_value({tag, ".period"}, 32'(if1.period_done), 32'h0);
      check_value({tag, ".lockup"}, 32'(if1.lockup), 32'h0);
      check_value({tag, ".d4.lfsr"}, 32'(if4.lfsr_out), 32'h1);
   endtask

   // Scoreboard: one expectation pushed per driven cycle, popped after the following edge
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.phase == "period" && if1.period_done === 1'b1) per_pulses++;
         if (e.chk) begin
            check_value({e.phase, ".d1.lfsr"},   32'(if1.lfsr_out),    32'(e.a.lfsr));
            check_value({e.phase, ".d1.cnt"},    32'(if1.step_cnt),    32'(e.a.cnt));
            check_value({e.phase, ".d1.valid"},  32'(if1.out_valid),   32'(e.a.valid));
            check_value({e.phase, ".d1.period"}, 32'(if1.period_done), 32'(e.a.period));
            check_value({e.phase, ".d1.lockup"}, 32'(if1.lockup),      32'(e.a.lock));
            check_value({e.phase, ".d4.lfsr"},   32'(if4.lfsr_out),    32'(e.b.lfsr));
            check_value({e.phase, ".d4.cnt"},    32'(if4.step_cnt),    32'(e.b.cnt));
            check_value({e.phase, ".d4.valid"},  32'(if4.out_valid),   32'(e.b.valid));
            check_value({e.phase, ".d4.period"}, 32'(if4.period_done), 32'(e.b.period));
            check_value({e.phase, ".d4.lockup"}, 32'(if4.lockup),      32'(e.b.lock));
         end
      end
   end

   initial begin
      resetn = 1'b0;  en = 1'b0;  load = 1'b0;  seed = 16'h0000;  out_ready = 1'b0;
      m1 = mdl_rst();
      m4 = mdl_rst();
      repeat (2) @(posedge clk);
      #2;
      reset_check("por");
      @(negedge clk);
      resetn = 1'b1;

      phase = "idle";
      repeat (2) drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

      phase = "seed10";
      drive(1'b1, 1'b1, 16'd10, 1'b1, 1'b1);
      expect_now("seed10.w0", 16'h000A, 16'd0);
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      expect_now("seed10.w1", 16'h0014, 16'd1);
      check_value("seed10.d4.step4", 32'(if4.lfsr_out), 32'h00A0);
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      expect_now("seed10.w2", 16'h0028, 16'd2);
      repeat (4) drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);

      phase = "bp";
      repeat (5) drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      expect_now("bp.stall", 16'h0280, 16'd6);
      check_value("bp.valid", 32'(if1.out_valid), 32'h1);
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      expect_now("bp.resume", 16'h0500, 16'd7);

      phase = "hold";
      repeat (2) drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
      repeat (2) drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);

      phase = "p8000";
      drive(1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      expect_now("p8000", 16'h0001, 16'd1);
      check_value("p8000.d4", 32'(if4.lfsr_out), 32'h0008);

      phase = "ldpri";
      drive(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
      expect_now("ldpri", 16'h1234, 16'd0);

      phase = "ldhold";
      drive(1'b0, 1'b1, 16'h00F0, 1'b1, 1'b1);
      repeat (2) drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      expect_now("ldhold", 16'h00F0, 16'd0);
      check_value("ldhold.valid", 32'(if1.out_valid), 32'h0);

      phase = "zero";
      drive(1'b1, 1'b1, 16'h0000, 1'b1, 1'b1);
      expect_now("zero", ZERO_EXP, 16'd0);
      check_value("zero.lockup", 32'(if1.lockup), 32'(ZERO_LOCK));
      repeat (2) drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);

      // asynchronous reset in the middle of a cycle, no clock edge involved
      phase = "midrst";
      @(posedge clk);
      #3;
      resetn = 1'b0;
      q.delete();
      #1;
      reset_check("midrst");
      en = 1'b0;  load = 1'b0;  out_ready = 1'b0;
      m1 = mdl_rst();
      m4 = mdl_rst();
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;

      phase = "idle2run";
      repeat (2) drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      expect_now("idle2run", 16'h0002, 16'd1);

      phase = "ld36";
      drive(1'b1, 1'b1, 16'h00C3, 1'b1, 1'b1);
      expect_now("ld36.load", 16'h00C3, 16'd0);
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      expect_now("ld36.step", 16'h0186, 16'd1);
      check_value("ld36.d4", 32'(if4.lfsr_out), 32'h0C31);

      phase = "period";
      drive(1'b1, 1'b1, 16'h0001, 1'b1, 1'b1);
      for (int i = 1; i <= 65535; i++) begin
         drive(1'b1, 1'b0, 16'h0000, 1'b1, (i % 4096 == 0) || (i >= 65534));
      end
      expect_now("period.end", 16'h0001, 16'hFFFF);
      check_value("period.pulse", 32'(if1.period_done), 32'h1);
      check_value("period.count", 32'(per_pulses), 32'd1);

      phase = "tail";
      drive(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
      repeat (2) @(posedge clk);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16: LFSR register width, legal 4..32.
REQ-002 Parameter TAPS, default 16'hB400: Fibonacci feedback mask; bit i set means state[i] enters the XOR.
REQ-003 Parameter STEP, default 1: single-bit shifts per accepted output, legal 1..WIDTH.
REQ-004 Parameter RESET_SEED, default 1: state value loaded by reset.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 en  input  1  run enable.
REQ-008 load  input  1  single-cycle request to load seed.
REQ-009 seed  input  WIDTH  seed value, sampled when load=1.
REQ-010 out_ready  input  1  consumer accepts lfsr_out.
REQ-011 out_valid  output  1  lfsr_out is a valid sequence word.
REQ-012 lfsr_out  output  WIDTH  current LFSR state, registered.
REQ-013 step_cnt  output  WIDTH  accepted steps since last load or reset, wraps modulo 2^WIDTH.
REQ-014 period_done  output  1  one-cycle pulse when the sequence returns to its start value.
REQ-015 lockup  output  1  one-cycle pulse on all-zero correction (macro-dependent).

Function
REQ-016 The FSM SHALL have states IDLE, RUN and HOLD; out_valid SHALL be 1 only in RUN.
REQ-017 A single shift SHALL compute fb = XOR of (state AND TAPS) and next = {state[WIDTH-2:0], fb}.
REQ-018 An accepted step (out_valid=1 and out_ready=1) SHALL apply STEP single shifts in one cycle and increment step_cnt by 1.
REQ-019 out_valid=1 with out_ready=0 SHALL hold lfsr_out and step_cnt unchanged.
REQ-020 load=1 in any state SHALL, on the next edge, set lfsr_out=seed, set the start value to seed, clear step_cnt, and enter RUN if en=1, else HOLD.
REQ-021 load SHALL take priority over a simultaneous accepted step; that step SHALL be discarded.
REQ-022 IDLE SHALL go to RUN when en=1, using RESET_SEED as the start value.
REQ-023 RUN SHALL go to HOLD when en=0 and load=0; HOLD SHALL go to RUN when en=1.
REQ-024 HOLD SHALL freeze lfsr_out and step_cnt.
REQ-025 period_done SHALL pulse in the cycle after an accepted step whose new state equals the start value.
REQ-026 Latency from load to the first valid word SHALL be 1 cycle.

Reset
REQ-027 resetn=0 SHALL immediately force state IDLE, lfsr_out=RESET_SEED, start value=RESET_SEED, step_cnt=0, out_valid=0, period_done=0, lockup=0.
REQ-028 Reset asserted mid-sequence SHALL discard all progress; release SHALL behave identically to power-up.

Configuration
REQ-029 Macro LFSR_GEN_LOCKUP_EN defined: a load of seed 0 SHALL load 1 instead, and an all-zero state after a step SHALL be replaced by 1; either event SHALL pulse lockup for one cycle.
REQ-030 LFSR_GEN_LOCKUP_EN undefined: zero SHALL be loaded as-is, the state SHALL remain 0 on every step, and lockup SHALL be tied to 0.

Verification
REQ-031 Reset, then load seed=16'd10 with en=1 and out_ready=1 -> lfsr_out=0x000A, then 0x0014, 0x0028, ...; step_cnt=1, 2, ...
REQ-032 Load seed=16'h8000 and apply one accepted step -> lfsr_out=0x0001.
REQ-033 Hold out_ready=0 for 5 cycles in RUN -> lfsr_out and step_cnt are stable and out_valid=1; then 0->1 resumes with the next word.
REQ-034 Free-run from seed=1 with default parameters -> period_done pulses exactly once at step_cnt=65535, with lfsr_out=0x0001.
REQ-035 Load seed=0 -> with the macro defined, lfsr_out=0x0001 and lockup pulses; without it, lfsr_out stays 0x0000 and lockup=0.
REQ-036 Assert resetn=0 mid-run, then drive load and out_ready together -> outputs take their reset values asynchronously; load wins over the step, and STEP=4 advances 4 shifts per accepted word.
